// File: rtl/banked_data_memory_pkg.sv
// Shared definitions for the banked data memory: default sizes, response
// FSM states and the bank-select width helper.
package data_mem_pkg;

    localparam int DEFAULT_NUM_BANKS   = 4;
    localparam int DEFAULT_BANK_ADDR_W = 16;
    localparam int DEFAULT_DATA_W      = 32;
    localparam int DEFAULT_ADDR_W      = 32;
    localparam int ERR_COUNT_W         = 16;

    typedef enum logic {
        RSP_EMPTY = 1'b0,
        RSP_FULL  = 1'b1
    } rsp_state_e;

    // A single bank still needs a one-bit select so the port widths stay legal
    function automatic int bank_sel_w(input int num_banks);
        return (num_banks > 1) ? $clog2(num_banks) : 1;
    endfunction

endpackage

// File: rtl/banked_data_memory_if.sv
// Request/response bus of the banked data memory; slave is the memory side.
interface banked_data_memory_if #(
    parameter int DATA_W = data_mem_pkg::DEFAULT_DATA_W,
    parameter int ADDR_W = data_mem_pkg::DEFAULT_ADDR_W
) ();

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_wren_i;
    logic [ADDR_W-1:0]     req_addr_i;
    logic [DATA_W/8-1:0]   req_be_i;
    logic [DATA_W-1:0]     req_data_i;
    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_W-1:0]     rsp_data_o;
    logic                  rsp_err_o;
    logic [15:0]           err_count_o;

    modport slave (
        input  req_valid_i, req_wren_i, req_addr_i, req_be_i, req_data_i, rsp_ready_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, err_count_o
    );

    modport master (
        output req_valid_i, req_wren_i, req_addr_i, req_be_i, req_data_i, rsp_ready_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, err_count_o
    );

endinterface

// File: rtl/banked_data_memory_bank.sv
// Single-port synchronous RAM with per-byte write enables; read data is
// registered and only changes when the bank is enabled.
module data_mem_bank #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                en_i,
    input  logic                we_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < DATA_W/8; b++) begin
                    if (be_i[b]) begin
                        mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                    end
                end
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_data_memory.sv
// Banked data memory: decodes bank/offset, flags out-of-range addresses and
// returns one in-order response per request through a two-state response FSM.
module banked_data_memory
    import data_mem_pkg::*;
#(
    parameter int NUM_BANKS   = DEFAULT_NUM_BANKS,
    parameter int BANK_ADDR_W = DEFAULT_BANK_ADDR_W,
    parameter int DATA_W      = DEFAULT_DATA_W,
    parameter int ADDR_W      = DEFAULT_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    banked_data_memory_if.slave   bus
);

    localparam int SEL_W     = bank_sel_w(NUM_BANKS);
    localparam int UPPER_LSB = BANK_ADDR_W + SEL_W;

    rsp_state_e               state_q;
    logic [SEL_W-1:0]         bank_sel_q;
    logic                     rsp_err_q;
    logic                     rsp_wr_q;
    logic [DATA_W-1:0]        hold_q;
    logic                     hold_vld_q;
    logic [ERR_COUNT_W-1:0]   err_count_q;
    logic [ERR_COUNT_W-1:0]   err_count_d;

    logic [BANK_ADDR_W-1:0]   req_off;
    logic [SEL_W-1:0]         req_bank;
    logic                     addr_err;
    logic                     req_ready;
    logic                     accept;
    logic [DATA_W-1:0]        live_data;
    logic [DATA_W-1:0]        bank_rdata [NUM_BANKS];

    assign req_off   = bus.req_addr_i[BANK_ADDR_W-1:0];
    assign req_bank  = bus.req_addr_i[BANK_ADDR_W +: SEL_W];
    assign addr_err  = |(bus.req_addr_i[ADDR_W-1:0] >> UPPER_LSB);
    assign req_ready = !((state_q == RSP_FULL) && !bus.rsp_ready_i);
    // Reset gates acceptance so the unreset RAMs cannot be written during reset
    assign accept    = bus.req_valid_i && req_ready && rst_n;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic bank_en;
        assign bank_en = accept && !addr_err && (req_bank == SEL_W'(b));

        data_mem_bank #(
            .ADDR_W (BANK_ADDR_W),
            .DATA_W (DATA_W)
        ) u_bank (
            .clk     (clk),
            .en_i    (bank_en),
            .we_i    (bank_en && bus.req_wren_i),
            .be_i    (bus.req_be_i),
            .addr_i  (req_off),
            .wdata_i (bus.req_data_i),
            .rdata_o (bank_rdata[b])
        );
    end

    // Mux on the select captured at acceptance, never the live address
    assign live_data   = (rsp_err_q || rsp_wr_q) ? '0 : bank_rdata[bank_sel_q];
    assign err_count_d = (accept && addr_err && (err_count_q != {ERR_COUNT_W{1'b1}}))
                         ? err_count_q + 1'b1 : err_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RSP_EMPTY;
            bank_sel_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_wr_q    <= 1'b0;
            hold_q      <= '0;
            hold_vld_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_count_q <= err_count_d;
            if (accept) begin
                state_q    <= RSP_FULL;
                bank_sel_q <= req_bank;
                rsp_err_q  <= addr_err;
                rsp_wr_q   <= bus.req_wren_i;
                hold_vld_q <= 1'b0;
            end else begin
                case (state_q)
                    RSP_EMPTY: state_q <= RSP_EMPTY;
                    RSP_FULL: begin
                        if (bus.rsp_ready_i) begin
                            state_q    <= RSP_EMPTY;
                            hold_vld_q <= 1'b0;
                        end else if (!hold_vld_q) begin
                            hold_q     <= live_data;
                            hold_vld_q <= 1'b1;
                        end
                    end
                    default: state_q <= RSP_EMPTY;
                endcase
            end
        end
    end

    assign bus.req_ready_o = req_ready;
    assign bus.rsp_valid_o = (state_q == RSP_FULL);
    assign bus.rsp_err_o   = (state_q == RSP_FULL) && rsp_err_q;
    assign bus.rsp_data_o  = (state_q != RSP_FULL) ? '0 : (hold_vld_q ? hold_q : live_data);
    assign bus.err_count_o = err_count_q;

endmodule

// File: tb/tb_banked_data_memory.sv
// Directed and randomized bench for banked_data_memory against a word-level
// model of memory contents and error count.
module tb_banked_data_memory;

    logic clk;
    logic rst_n;
    int   checkCount;
    int   errorCount;

    logic [31:0] modelMem [logic [17:0]];
    int          modelErr;

    banked_data_memory_if #(.DATA_W(32), .ADDR_W(32)) bus ();

    banked_data_memory #(
        .NUM_BANKS   (4),
        .BANK_ADDR_W (16),
        .DATA_W      (32),
        .ADDR_W      (32)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) else begin
            errorCount++;
            $error("[TB] FAIL %s: observed 'h%0h expected 'h%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [31:0] makeAddr(input int upper, input int bank, input int off);
        logic [31:0] a;
        a = {14'(upper), 2'(bank), 16'(off)};
        return a;
    endfunction

    // One accepted request with the consumer always ready; the model decides the response
    task automatic applyStimulus(input logic wren, input logic [31:0] addr,
                                 input logic [3:0] be, input logic [31:0] data);
        logic        isErr;
        logic        known;
        logic [31:0] expData;
        logic [31:0] word;
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_wren_i  = wren;
        bus.req_addr_i  = addr;
        bus.req_be_i    = be;
        bus.req_data_i  = data;
        bus.rsp_ready_i = 1'b1;
        checkOutput("req_ready", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        isErr   = (addr[31:18] != 14'd0);
        known   = 1'b1;
        expData = 32'd0;
        if (isErr) begin
            if (modelErr < 65535) modelErr++;
        end else if (wren) begin
            word = modelMem.exists(addr[17:0]) ? modelMem[addr[17:0]] : 32'd0;
            for (int b = 0; b < 4; b++) begin
                if (be[b]) word[b*8 +: 8] = data[b*8 +: 8];
            end
            modelMem[addr[17:0]] = word;
        end else if (modelMem.exists(addr[17:0])) begin
            expData = modelMem[addr[17:0]];
        end else begin
            known = 1'b0;
        end
        checkOutput("rsp_valid", 32'(bus.rsp_valid_o), 32'd1);
        checkOutput("rsp_err", 32'(bus.rsp_err_o), 32'(isErr));
        if (known) checkOutput("rsp_data", bus.rsp_data_o, expData);
        checkOutput("err_count", 32'(bus.err_count_o), 32'(modelErr));
    endtask

    task automatic idleCycle();
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
    endtask

    initial begin
        logic [31:0] expA;
        logic [31:0] expB;
        logic [31:0] addr;
        int          r;

        checkCount = 0;
        errorCount = 0;
        modelErr   = 0;
        rst_n            = 1'b0;
        bus.req_valid_i  = 1'b0;
        bus.req_wren_i   = 1'b0;
        bus.req_addr_i   = '0;
        bus.req_be_i     = '0;
        bus.req_data_i   = '0;
        bus.rsp_ready_i  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("reset_rsp_err", 32'(bus.rsp_err_o), 32'd0);
        checkOutput("reset_rsp_data", bus.rsp_data_o, 32'd0);
        checkOutput("reset_err_count", 32'(bus.err_count_o), 32'd0);
        checkOutput("reset_req_ready", 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] same offset in banks 0 and 3");
        applyStimulus(1'b1, makeAddr(0, 0, 'h10), 4'hF, 32'hDEADBEEF);
        applyStimulus(1'b1, makeAddr(0, 3, 'h10), 4'hF, 32'h0BADF00D);
        applyStimulus(1'b0, makeAddr(0, 0, 'h10), 4'h0, 32'h0);
        applyStimulus(1'b0, makeAddr(0, 3, 'h10), 4'h0, 32'h0);
        idleCycle();

        $display("[TB] partial byte write");
        applyStimulus(1'b1, makeAddr(0, 1, 'h20), 4'hF, 32'h11223344);
        applyStimulus(1'b1, makeAddr(0, 1, 'h20), 4'b0010, 32'h0000AA00);
        applyStimulus(1'b0, makeAddr(0, 1, 'h20), 4'h0, 32'h0);
        checkOutput("partial_literal", bus.rsp_data_o, 32'h1122AA44);

        $display("[TB] out-of-range address");
        applyStimulus(1'b0, 32'h0004_0000, 4'h0, 32'h0);
        checkOutput("oor_count_literal", 32'(bus.err_count_o), 32'd1);
        applyStimulus(1'b1, 32'h0004_0010, 4'hF, 32'h55555555);
        applyStimulus(1'b0, makeAddr(0, 0, 'h10), 4'h0, 32'h0);
        applyStimulus(1'b0, makeAddr(0, 0, 0), 4'h0, 32'h0);
        idleCycle();

        $display("[TB] response backpressure");
        expA = modelMem[18'(makeAddr(0, 0, 'h10))];
        expB = modelMem[18'(makeAddr(0, 3, 'h10))];
        @(negedge clk);
        bus.req_valid_i = 1'b1;
        bus.req_wren_i  = 1'b0;
        bus.req_addr_i  = makeAddr(0, 0, 'h10);
        bus.rsp_ready_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("stall_first_valid", 32'(bus.rsp_valid_o), 32'd1);
        checkOutput("stall_first_data", bus.rsp_data_o, expA);
        @(negedge clk);
        bus.req_addr_i = makeAddr(0, 3, 'h10);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("stall_valid", 32'(bus.rsp_valid_o), 32'd1);
            checkOutput("stall_data", bus.rsp_data_o, expA);
            checkOutput("stall_req_ready", 32'(bus.req_ready_o), 32'd0);
        end
        @(negedge clk);
        bus.rsp_ready_i = 1'b1;
        #1;
        checkOutput("release_req_ready", 32'(bus.req_ready_o), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("release_valid", 32'(bus.rsp_valid_o), 32'd1);
        checkOutput("release_data", bus.rsp_data_o, expB);
        idleCycle();

        $display("[TB] back-to-back alternating banks 1/2");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, makeAddr(0, 1, 'h30 + i), 4'hF, $urandom);
            applyStimulus(1'b1, makeAddr(0, 2, 'h30 + i), 4'hF, $urandom);
        end
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, makeAddr(0, 1 + (i % 2), 'h30 + i / 2), 4'h0, 32'h0);
        end
        idleCycle();

        $display("[TB] randomized traffic");
        for (int i = 0; i < 200; i++) begin
            r = $urandom_range(0, 9);
            addr = makeAddr(0, $urandom_range(0, 3), 'h100 + $urandom_range(0, 7));
            if (r == 0) addr[31:18] = 14'($urandom_range(1, 16383));
            if (r == 9) idleCycle();
            applyStimulus(1'($urandom_range(0, 1)), addr, 4'($urandom), $urandom);
        end

        $display("[TB] reset while a response is outstanding");
        applyStimulus(1'b1, makeAddr(0, 2, 'h40), 4'hF, 32'hCAFEF00D);
        applyStimulus(1'b0, makeAddr(0, 2, 'h40), 4'h0, 32'h0);
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        checkOutput("midrst_req_ready", 32'(bus.req_ready_o), 32'd1);
        checkOutput("midrst_err_count", 32'(bus.err_count_o), 32'd0);
        bus.req_valid_i = 1'b1;
        bus.req_wren_i  = 1'b1;
        bus.req_addr_i  = makeAddr(0, 2, 'h40);
        bus.req_be_i    = 4'hF;
        bus.req_data_i  = 32'h0BADBEEF;
        @(posedge clk);
        #1;
        checkOutput("inrst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        rst_n = 1'b1;
        modelErr = 0;
        applyStimulus(1'b0, makeAddr(0, 2, 'h40), 4'h0, 32'h0);
        checkOutput("postrst_literal", bus.rsp_data_o, 32'hCAFEF00D);
        applyStimulus(1'b0, makeAddr(0, 1, 'h20), 4'h0, 32'h0);
        idleCycle();

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/banked_data_memory.md
BANKED_DATA_MEMORY -- requirements
Module: banked_data_memory

Interface
REQ-001 Parameter NUM_BANKS, default 4: number of data memory banks; power of two, 2..16.
REQ-002 Parameter BANK_ADDR_W, default 16: word-address width inside one bank.
REQ-003 Parameter DATA_W, default 32: word width; multiple of 8.
REQ-004 Parameter ADDR_W, default 32: request address width; at least BANK_ADDR_W+log2(NUM_BANKS).
REQ-005 CLK  in  1  single system clock; all state on rising edge.
REQ-006 RST_n  in  1  asynchronous, active-low reset.
REQ-007 req_valid_i  in  1  request present.
REQ-008 req_ready_o  out  1  request may be accepted this cycle.
REQ-009 req_wren_i  in  1  1 = write, 0 = read.
REQ-010 req_addr_i  in  ADDR_W  word address: [BANK_ADDR_W-1:0] offset, next log2(NUM_BANKS) bits bank select, remaining upper bits must be zero.
REQ-011 req_be_i  in  DATA_W/8  byte enables for writes; ignored on reads.
REQ-012 req_data_i  in  DATA_W  write data.
REQ-013 rsp_valid_o  out  1  response present.
REQ-014 rsp_ready_i  in  1  consumer accepts response.
REQ-015 rsp_data_o  out  DATA_W  read data; zero for writes and errors.
REQ-016 rsp_err_o  out  1  request address out of range.
REQ-017 err_count_o  out  16  saturating count of errored requests.

Function
REQ-018 A request SHALL be accepted on a rising edge where req_valid_i && req_ready_o.
REQ-019 Every accepted request SHALL produce exactly one response, in order.
REQ-020 Response SHALL appear with rsp_valid_o=1 in the cycle after acceptance (latency 1).
REQ-021 req_ready_o SHALL equal !(rsp_valid_o && !rsp_ready_i); at most one response outstanding.
REQ-022 Bank select SHALL be registered at acceptance, and the read mux SHALL use the registered select, never the live address.
REQ-023 Write SHALL update only the selected bank, only enabled bytes; all other banks unchanged.
REQ-024 Address with nonzero upper bits SHALL set rsp_err_o=1, rsp_data_o=0, perform no write, and increment err_count_o.
REQ-025 err_count_o SHALL saturate at 16'hFFFF.
REQ-026 If rsp_valid_o && !rsp_ready_i, response data/err SHALL be captured into a hold register and held stable until rsp_ready_i=1.
REQ-027 Response control SHALL be a two-state FSM: EMPTY (rsp_valid_o=0) -> FULL on accept; FULL -> EMPTY on rsp_ready_i without new accept; FULL -> FULL on rsp_ready_i with same-cycle accept; FULL with !rsp_ready_i holds.
REQ-028 Read of an address written in the immediately preceding accepted request SHALL return the new data (bank write-first or forwarded).
REQ-029 Read data SHALL be uninitialised-safe: bank contents undefined until written; bench only checks written locations.

Reset
REQ-030 On RST_n=0: rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0, err_count_o=0, FSM=EMPTY, req_ready_o=1, hold register cleared.
REQ-031 Reset mid-response SHALL discard the outstanding response; memory contents are not cleared.
REQ-032 A request presented while RST_n=0 SHALL NOT be accepted and SHALL NOT write.

Structure
REQ-033 Default parameters, the response FSM state enum and a bank-select width function SHALL live in shared package data_mem_pkg.
REQ-034 One sub-module data_mem_bank (single-port synchronous RAM with byte enables, BANK_ADDR_W x DATA_W) SHALL be instantiated NUM_BANKS times via generate.

Verification
REQ-035 Write 32'hDEADBEEF to bank 0 off 0x10, bank 3 off 0x10; read both -> each returns its own value next cycle, rsp_err_o=0.
REQ-036 Write 32'h11223344 then partial write be=4'b0010 data 32'h0000AA00 same address; read -> 32'h1122AA44.
REQ-037 Read with req_addr_i=32'h0004_0000 (NUM_BANKS=4) -> rsp_err_o=1, rsp_data_o=0, err_count_o=1, no bank modified.
REQ-038 Hold rsp_ready_i=0 for 3 cycles after read -> rsp_data_o stable, req_ready_o=0, then one response on release, no loss or duplication.
REQ-039 Back-to-back reads alternating banks 1/2 with rsp_ready_i=1 -> one response per cycle, data matches bank of each request.
REQ-040 Assert RST_n=0 while FULL -> rsp_valid_o=0 immediately; after release previously written data still readable.
